// File: rtl/timer_bank.sv
// Multi-channel up-counting timer bank. Each channel has its own limit,
// prescaler, periodic/one-shot mode, sticky expiry flag and interrupt enable.
module timer_bank_chan #(
    parameter int WIDTH          = 32,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wrCount,
    input  logic                      wrLimit,
    input  logic                      wrCtrl,
    input  logic [WIDTH-1:0]          wrData,
    input  logic                      flagClr,
    output logic [WIDTH-1:0]          count,
    output logic [WIDTH-1:0]          limit,
    output logic [WIDTH-1:0]          ctrlWord,
    output logic                      irqEn,
    output logic                      expired
);
    logic                      en;
    logic                      oneShot;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic [PRESCALE_WIDTH-1:0] psc;
    logic                      tick;
    logic                      live;
    logic                      atLimit;

    assign tick    = en && (psc == prescale);
    // A count or ctrl write swallows the tick; a limit write does not.
    assign live    = tick && !wrCount && !wrCtrl;
    assign atLimit = (count >= limit);

    always_comb begin
        ctrlWord                          = '0;
        ctrlWord[0]                       = en;
        ctrlWord[1]                       = oneShot;
        ctrlWord[2]                       = irqEn;
        ctrlWord[8 +: PRESCALE_WIDTH]     = prescale;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            limit    <= '1;
            en       <= 1'b0;
            oneShot  <= 1'b0;
            irqEn    <= 1'b0;
            prescale <= '0;
            psc      <= '0;
            expired  <= 1'b0;
        end else begin
            if (wrLimit)
                limit <= wrData;

            if (wrCount || (wrCtrl && wrData[0] && !en) || tick)
                psc <= '0;
            else if (en)
                psc <= psc + 1'b1;

            if (wrCount)
                count <= wrData;
            else if (live) begin
                if (!atLimit)
                    count <= count + 1'b1;
                else if (!oneShot)
                    count <= '0;
            end

            if (wrCtrl) begin
                en       <= wrData[0];
                oneShot  <= wrData[1];
                irqEn    <= wrData[2];
                prescale <= wrData[8 +: PRESCALE_WIDTH];
            end else if (live && atLimit && oneShot)
                en <= 1'b0;

            // Set beats clear so an expiry is never lost to a coincident clear.
            if (live && atLimit)
                expired <= 1'b1;
            else if (flagClr)
                expired <= 1'b0;
        end
    end
endmodule

module timer_bank #(
    parameter int CHANNELS       = 4,
    parameter int WIDTH          = 32,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              wrEn,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] wrChan,
    input  logic [1:0]                                        wrField,
    input  logic [WIDTH-1:0]                                  wrData,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] rdChan,
    input  logic [1:0]                                        rdField,
    output logic [WIDTH-1:0]                                  rdData,
    input  logic [CHANNELS-1:0]                               flagClr,
    output logic [CHANNELS*WIDTH-1:0]                         countOut,
    output logic [CHANNELS-1:0]                               expired,
    output logic                                              irq
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0][WIDTH-1:0] cnt;
    logic [CHANNELS-1:0][WIDTH-1:0] lim;
    logic [CHANNELS-1:0][WIDTH-1:0] ctl;
    logic [CHANNELS-1:0]            irqEnVec;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        // Out-of-range channel numbers never match any instance.
        logic sel;
        assign sel = wrEn && (wrChan == CW'(i));

        timer_bank_chan #(
            .WIDTH          (WIDTH),
            .PRESCALE_WIDTH (PRESCALE_WIDTH)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .wrCount  (sel && (wrField == 2'd0)),
            .wrLimit  (sel && (wrField == 2'd1)),
            .wrCtrl   (sel && (wrField == 2'd2)),
            .wrData   (wrData),
            .flagClr  (flagClr[i]),
            .count    (cnt[i]),
            .limit    (lim[i]),
            .ctrlWord (ctl[i]),
            .irqEn    (irqEnVec[i]),
            .expired  (expired[i])
        );
    end

    assign countOut = cnt;
    assign irq      = |(expired & irqEnVec);

    always_comb begin
        rdData = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rdChan == CW'(i)) begin
                case (rdField)
                    2'd0:    rdData = cnt[i];
                    2'd1:    rdData = lim[i];
                    2'd2:    rdData = ctl[i];
                    default: rdData = WIDTH'(expired);
                endcase
            end
        end
    end
endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: periodic, prescaled, one-shot, collisions,
// lowered limit and asynchronous reset, checked with immediate assertions.
module tb_timer_bank;
    localparam int CH = 4;
    localparam int W  = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            wrEn;
    logic [1:0]      wrChan;
    logic [1:0]      wrField;
    logic [W-1:0]    wrData;
    logic [1:0]      rdChan;
    logic [1:0]      rdField;
    logic [W-1:0]    rdData;
    logic [CH-1:0]   flagClr;
    logic [CH*W-1:0] countOut;
    logic [CH-1:0]   expired;
    logic            irq;

    int nvec = 0;
    int nerr = 0;

    timer_bank #(.CHANNELS(CH), .WIDTH(W), .PRESCALE_WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .wrEn     (wrEn),
        .wrChan   (wrChan),
        .wrField  (wrField),
        .wrData   (wrData),
        .rdChan   (rdChan),
        .rdField  (rdField),
        .rdData   (rdData),
        .flagClr  (flagClr),
        .countOut (countOut),
        .expired  (expired),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int fld, input logic [W-1:0] d);
        wrEn    = 1'b1;
        wrChan  = 2'(ch);
        wrField = 2'(fld);
        wrData  = d;
        step();
        wrEn    = 1'b0;
    endtask

    function automatic logic [W-1:0] cnt(input int ch);
        return countOut[ch*W +: W];
    endfunction

    task automatic rd(input int ch, input int fld);
        rdChan  = 2'(ch);
        rdField = 2'(fld);
        #1;
    endtask

    initial begin
        reset = 1'b1; wrEn = 1'b0; wrChan = '0; wrField = '0; wrData = '0;
        rdChan = 2'd3; rdField = 2'd1; flagClr = '0;
        #12;
        chk("rst_count", countOut, '0);
        chk("rst_expired", expired, '0);
        chk("rst_irq", irq, 1'b0);
        chk("rst_limit", rdData, 32'hFFFF_FFFF);
        @(negedge clk);
        reset = 1'b0;

        // periodic ch0, limit 3, en|irqEn
        wr(0, 1, 3);
        wr(0, 2, 32'h5);
        repeat (3) step();
        chk("p_cnt3", cnt(0), 3);
        chk("p_noexp", expired[0], 1'b0);
        chk("p_noirq", irq, 1'b0);
        step();
        chk("p_wrap", cnt(0), 0);
        chk("p_exp", expired[0], 1'b1);
        chk("p_irq", irq, 1'b1);
        flagClr = 4'b0001; step(); flagClr = '0;
        chk("p_clr", expired[0], 1'b0);
        chk("p_clr_irq", irq, 1'b0);
        chk("p_cnt1", cnt(0), 1);
        wr(0, 0, 100);
        chk("col_wrcount", cnt(0), 100);
        flagClr = 4'b0001; step(); flagClr = '0;
        chk("col_setwins", expired[0], 1'b1);
        chk("col_reset0", cnt(0), 0);
        flagClr = 4'b0001; wr(0, 2, 0); flagClr = '0;
        chk("p_off_exp", expired[0], 1'b0);
        chk("p_off_cnt", cnt(0), 0);

        // prescaled ch1, limit 2, prescale 4
        wr(1, 1, 2);
        wr(1, 2, 32'h401);
        repeat (4) step();
        chk("ps_c0", cnt(1), 0);
        step();
        chk("ps_c1", cnt(1), 1);
        repeat (4) step();
        chk("ps_c1b", cnt(1), 1);
        step();
        chk("ps_c2", cnt(1), 2);
        repeat (4) step();
        chk("ps_noexp", expired[1], 1'b0);
        step();
        chk("ps_exp15", expired[1], 1'b1);
        chk("ps_wrap", cnt(1), 0);
        chk("ps_noirq", irq, 1'b0);
        flagClr = 4'b0010; wr(1, 2, 0); flagClr = '0;
        chk("ps_clr", expired[1], 1'b0);

        // one-shot ch2, limit 5
        wr(2, 1, 5);
        wr(2, 2, 32'h3);
        repeat (5) step();
        chk("os_c5", cnt(2), 5);
        chk("os_noexp", expired[2], 1'b0);
        step();
        chk("os_hold", cnt(2), 5);
        chk("os_exp", expired[2], 1'b1);
        rd(2, 2);
        chk("os_en_off", rdData, 32'h2);
        repeat (2) step();
        chk("os_hold2", cnt(2), 5);
        flagClr = 4'b0100; step(); flagClr = '0;
        chk("os_clr", expired[2], 1'b0);
        wr(2, 2, 32'h3);
        chk("os_rearm_ctrl", rdData, 32'h3);
        chk("os_rearm_noexp", expired[2], 1'b0);
        step();
        chk("os_reexp", expired[2], 1'b1);
        chk("os_reexp_ctrl", rdData, 32'h2);
        chk("os_reexp_cnt", cnt(2), 5);

        // lowered limit on ch3; the coincident tick uses the old limit
        wr(3, 0, 50);
        wr(3, 2, 32'h1);
        chk("lim_c50", cnt(3), 50);
        wr(3, 1, 10);
        rd(3, 1);
        chk("lim_tick_old", cnt(3), 51);
        chk("lim_rd", rdData, 10);
        chk("lim_noexp", expired[3], 1'b0);
        step();
        chk("lim_wrap", cnt(3), 0);
        chk("lim_exp", expired[3], 1'b1);
        rd(0, 3);
        chk("rd_flags", rdData, 32'hC);
        chk("indep_c0", cnt(0), 0);
        chk("indep_c1", cnt(1), 0);
        chk("indep_c2", cnt(2), 5);
        chk("lim_noirq", irq, 1'b0);
        wr(3, 2, 32'h5);
        chk("irq_on", irq, 1'b1);
        chk("ctrlwr_noinc", cnt(3), 0);
        step();
        chk("c3_run", cnt(3), 1);

        // asynchronous reset mid-cycle
        #2 reset = 1'b1;
        rd(3, 1);
        chk("ar_count", countOut, '0);
        chk("ar_expired", expired, '0);
        chk("ar_irq", irq, 1'b0);
        chk("ar_limit", rdData, 32'hFFFF_FFFF);
        rd(3, 2);
        chk("ar_ctrl", rdData, 0);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("ar_idle", cnt(3), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
